// File: rtl/adder_bist_pkg.sv
// Shared definitions for the 4-bit adder built-in self test: FSM state
// encoding, sweep length, legal pipeline-latency bounds and the reference
// model for the adder result.
package adder_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One comparison for every {A,B} operand byte.
  localparam int SWEEP_LEN = 256;

  // Legal range for the adder-under-test latency.
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  // Reference result: upper nibble zero, lower nibble (A+B) mod 16.
  function automatic logic [7:0] expected_of(input logic [7:0] op);
    logic [3:0] sum;
    sum = op[7:4] + op[3:0];
    return {4'h0, sum};
  endfunction

endpackage

// File: rtl/adder_bist_pipe.sv
// LATENCY-deep delay line carrying {valid, operand, expected} so that each
// reference value lines up with the adder result it belongs to.
module adder_bist_pipe
  import adder_bist_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_operand,
  input  logic [7:0] in_expected,
  output logic       out_valid,
  output logic [7:0] out_operand,
  output logic [7:0] out_expected
);

  logic       vld_p [LATENCY];
  logic [7:0] op_p  [LATENCY];
  logic [7:0] exp_p [LATENCY];

  // Shift register; fully cleared on reset so an aborted sweep leaves nothing behind
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_p[i] <= 1'b0;
        op_p[i]  <= 8'h00;
        exp_p[i] <= 8'h00;
      end
    end else begin
      vld_p[0] <= in_valid;
      op_p[0]  <= in_operand;
      exp_p[0] <= in_expected;
      for (int i = 1; i < LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        op_p[i]  <= op_p[i-1];
        exp_p[i] <= exp_p[i-1];
      end
    end
  end

  assign out_valid    = vld_p[LATENCY-1];
  assign out_operand  = op_p[LATENCY-1];
  assign out_expected = exp_p[LATENCY-1];

endmodule

// File: rtl/adder_bist.sv
// Exhaustive self test of a 4-bit adder: sweeps every {A,B} operand byte,
// compares the returned sum against a delayed reference, and reports a
// pass flag, saturating mismatch count and the first failing operand.
// Optional build macro ADDER_BIST_UPPER_CHECK_EN: when defined, the upper
// nibble of dut_sum (expected zero) is also compared.
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] dut_sum,
  output logic [7:0] operand,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_count,
  output logic [7:0] first_fail
);

  localparam logic [7:0] LAST_OP   = 8'(SWEEP_LEN - 1);
  localparam logic [2:0] DRAIN_END = 3'(LATENCY - 1);

`ifdef ADDER_BIST_UPPER_CHECK_EN
  localparam logic [7:0] CMP_MASK = 8'hFF;
`else
  localparam logic [7:0] CMP_MASK = 8'h0F;
`endif

  state_t     state;
  logic [7:0] cnt;
  logic [2:0] drain_cnt;

  logic       pipe_valid;
  logic [7:0] pipe_operand;
  logic [7:0] pipe_expected;
  logic       mismatch;
  logic [7:0] fail_next;

  // Counter drives the adder only while sweeping; otherwise the bus rests at zero
  assign operand = (state == RUN) ? cnt : 8'h00;

  adder_bist_pipe #(
    .LATENCY(LATENCY)
  ) u_pipe (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (state == RUN),
    .in_operand  (operand),
    .in_expected (expected_of(operand)),
    .out_valid   (pipe_valid),
    .out_operand (pipe_operand),
    .out_expected(pipe_expected)
  );

  // Compare the returned sum with the reference that travelled with it; count saturates
  always_comb begin
    mismatch  = pipe_valid && (((dut_sum ^ pipe_expected) & CMP_MASK) != 8'h00);
    fail_next = fail_count;
    if (mismatch && (fail_count != 8'hFF)) begin
      fail_next = fail_count + 8'd1;
    end
  end

  // Sweep sequencer with registered status outputs and result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 8'h00;
      drain_cnt  <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= 8'h00;
      first_fail <= 8'h00;
    end else begin
      // Results from the delay line are folded in regardless of state; the
      // delay line is empty outside RUN/DRAIN so this only acts during a sweep.
      fail_count <= fail_next;
      if (mismatch && (fail_count == 8'h00)) begin
        first_fail <= pipe_operand;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            cnt        <= 8'h00;
            drain_cnt  <= 3'd0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_count <= 8'h00;
            first_fail <= 8'h00;
          end
        end
        RUN: begin
          cnt <= cnt + 8'd1;
          if (cnt == LAST_OP) begin
            state     <= DRAIN;
            drain_cnt <= 3'd0;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_END) begin
            // The last comparison lands on this same edge, so judge on fail_next
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fail_next == 8'h00);
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist.sv
// Self-checking bench for adder_bist with a behavioural adder under test
// that can be made ideal, stuck, dirty in the upper nibble, or too slow.
module tb_adder_bist;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] dut_sum;
  logic [7:0] operand;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] fail_count;
  logic [7:0] first_fail;

  int checks_total  = 0;
  int checks_passed = 0;

  // 0 ideal, 1 sum bit0 stuck at 0, 2 upper nibble 4'h1, 3 two-cycle latency
  int mode = 0;
  logic [7:0] s1 = 8'h00;
  logic [7:0] s2 = 8'h00;

  always #5 clk = ~clk;

  adder_bist #(.LATENCY(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dut_sum   (dut_sum),
    .operand   (operand),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_count(fail_count),
    .first_fail(first_fail)
  );

  // Behavioural adder under test: registered 4-bit add
  always @(posedge clk) begin
    s1 <= {4'h0, 4'(operand[7:4] + operand[3:0])};
    s2 <= s1;
  end

  always_comb begin
    case (mode)
      1:       dut_sum = s1 & 8'hFE;
      2:       dut_sum = s1 | 8'h10;
      3:       dut_sum = s2;
      default: dut_sum = s1;
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    checks_total++;
    if (act == exp) checks_passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Pulses start and returns the number of rising edges from the one that
  // samples start to the one after which done is visible.
  task automatic run_sweep(input int mid_pulse_at, output int edges);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    edges = 1;
    while (!done && edges < 400) begin
      start = (edges == mid_pulse_at);
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  typedef struct {
    string name;
    int    mode;
    int    exp_cycles;
    int    exp_pass;
    int    exp_fc;
    int    exp_ff;
  } vec_t;

  vec_t vecs[4];
  int   edges;

  initial begin
    reset = 1'b1;
    start = 1'b0;

    vecs[0] = '{"ideal",   0, 258, 1, 0,   8'h00};
    vecs[1] = '{"stuck0",  1, 258, 0, 128, 8'h01};
`ifdef ADDER_BIST_UPPER_CHECK_EN
    vecs[2] = '{"upper",   2, 258, 0, 255, 8'h00};
`else
    vecs[2] = '{"upper",   2, 258, 1, 0,   8'h00};
`endif
    vecs[3] = '{"lat2",    3, 258, 0, 255, 8'h01};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_operand",    int'(operand),    0);
    check("rst_busy",       int'(busy),       0);
    check("rst_done",       int'(done),       0);
    check("rst_pass",       int'(pass),       0);
    check("rst_fail_count", int'(fail_count), 0);
    check("rst_first_fail", int'(first_fail), 0);
    @(negedge clk) reset = 1'b0;

    // Table of full sweeps
    for (int i = 0; i < 4; i++) begin
      mode = vecs[i].mode;
      run_sweep(-1, edges);
      check({vecs[i].name, "_cycles"},     edges,            vecs[i].exp_cycles);
      check({vecs[i].name, "_pass"},       int'(pass),       vecs[i].exp_pass);
      check({vecs[i].name, "_fail_count"}, int'(fail_count), vecs[i].exp_fc);
      check({vecs[i].name, "_first_fail"}, int'(first_fail), vecs[i].exp_ff);
    end

    // Operand tracks the counter during RUN; results hold in DONE
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("run_busy",       int'(busy),    1);
    check("run_operand_00", int'(operand), 8'h00);
    repeat (8'h37) @(negedge clk);
    check("run_operand_37", int'(operand), 8'h37);
    edges = 0;
    while (!done && edges < 400) begin
      @(negedge clk);
      edges++;
    end
    check("seq_done_reached", int'(done), 1);
    repeat (5) @(negedge clk);
    check("done_hold",       int'(done),    1);
    check("done_busy",       int'(busy),    0);
    check("done_operand",    int'(operand), 0);
    check("done_pass_hold",  int'(pass),    1);

    // Reset at RUN cycle 100 with a faulty adder, then a clean full sweep
    mode = 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (99) @(negedge clk);
    check("pre_abort_busy", int'(busy), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_operand",    int'(operand),    0);
    check("abort_busy",       int'(busy),       0);
    check("abort_done",       int'(done),       0);
    check("abort_pass",       int'(pass),       0);
    check("abort_fail_count", int'(fail_count), 0);
    check("abort_first_fail", int'(first_fail), 0);
    @(negedge clk) reset = 1'b0;
    mode = 0;
    run_sweep(-1, edges);
    check("rerun_cycles",     edges,            258);
    check("rerun_pass",       int'(pass),       1);
    check("rerun_fail_count", int'(fail_count), 0);

    // Start pulsed mid-sweep is ignored
    run_sweep(50, edges);
    check("ignore_cycles", edges,      258);
    check("ignore_pass",   int'(pass), 1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/adder_bist.md
ADDER_BIST -- requirements
Module: adder_bist

Interface
REQ-001 Parameter LATENCY, default 1: DUT cycles from operand applied to result valid; legal 1..4.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse; begins a sweep when idle or done.
REQ-005 dut_sum  input  8  result byte from adder under test; [3:0] sum, [7:4] expected zero.
REQ-006 operand  output  8  operand byte to adder; [7:4]=A, [3:0]=B.
REQ-007 busy  output  1  high during sweep and drain.
REQ-008 done  output  1  high while in DONE state.
REQ-009 pass  output  1  valid when done; 1 = zero mismatches.
REQ-010 fail_count  output  8  mismatch count, saturating at 255.
REQ-011 first_fail  output  8  operand byte of first mismatch; 0x00 if none.

Function
REQ-012 FSM states IDLE, RUN, DRAIN, DONE shall be implemented.
REQ-013 IDLE/DONE + start -> RUN next cycle; clears fail_count, first_fail, pass, 8-bit counter.
REQ-014 In RUN, operand shall equal the registered counter; counter increments every cycle, 0x00..0xFF.
REQ-015 RUN -> DRAIN after the cycle driving 0xFF; DRAIN lasts LATENCY cycles -> DONE.
REQ-016 Expected value {4'h0, (A+B) mod 16} and a valid flag shall be delayed LATENCY cycles alongside each operand.
REQ-017 When the delayed valid is high, dut_sum shall be compared to the delayed expected value in that cycle.
REQ-018 On mismatch fail_count increments (holds at 255); first_fail loads the delayed operand only if fail_count was 0.
REQ-019 Exactly 256 comparisons per sweep; total start-to-done latency = 1 + 256 + LATENCY cycles.
REQ-020 pass shall be set on entry to DONE iff fail_count == 0, held until next start.
REQ-021 start in RUN or DRAIN shall be ignored.
REQ-022 operand shall be 0x00 in IDLE, DRAIN and DONE.
REQ-023 Results shall remain stable in DONE until start or reset.

Reset
REQ-024 reset shall force IDLE, operand=0x00, busy=0, done=0, pass=0, fail_count=0, first_fail=0x00, counter and delay line cleared.
REQ-025 reset mid-sweep shall abort immediately with no partial result; next start runs a full sweep.

Configuration
REQ-026 With ADDER_BIST_UPPER_CHECK_EN defined, comparison covers all 8 bits of dut_sum.
REQ-027 Without ADDER_BIST_UPPER_CHECK_EN, only dut_sum[3:0] is compared; [7:4] ignored.

Structure
REQ-028 Package adder_bist_pkg shall hold the FSM state enum, sweep length constant (256) and LATENCY bounds.
REQ-029 Sub-module adder_bist_pipe shall implement the LATENCY-deep delay line of {valid, operand, expected}.

Verification
REQ-030 Ideal registered adder, LATENCY=1, start pulse -> done at cycle 258, pass=1, fail_count=0, first_fail=0x00.
REQ-031 Adder with sum bit0 stuck at 0 -> pass=0, fail_count=128, first_fail=0x01.
REQ-032 Adder driving [7:4]=4'h1 -> with macro: fail_count=255, first_fail=0x00 mismatch, pass=0; without macro: pass=1.
REQ-033 DUT latency 2 vs LATENCY=1 -> pass=0, fail_count=255 (saturated).
REQ-034 reset asserted at RUN cycle 100 -> all outputs at reset values next edge; new start -> full clean sweep, pass=1.
REQ-035 start pulsed during RUN -> ignored; done still at cycle 258 from original start.
